relu2_channel_serializer: RTL

- Sits downstream of the layer-2 ReLU stage.
- Consumes its channel-parallel pixel stream, which is valid-only with no backpressure and carries CHANNELS words per pixel.
- Buffers whole pixel vectors in a small FIFO and re-emits them one channel word per cycle on a valid/ready stream, tagged with channel index, pixel index and frame markers, for the layer-3 loader / DMA writer.

---
 rtl/relu2_channel_serializer_pkg.sv | 17 +
 rtl/relu2_channel_serializer_vec_fifo.sv | 53 +++++
 rtl/relu2_channel_serializer.sv | 100 ++++++++++
 3 files changed

// File: rtl/relu2_channel_serializer_pkg.sv
// Shared layer-2 constants and the channel-parallel pixel vector type.
package relu2_channel_serializer_pkg;

    localparam int DATA_BITS    = 32;
    localparam int CHANNELS     = 64;
    localparam int IMAGE_WIDTH  = 13;
    localparam int IMAGE_HEIGHT = 17;
    localparam int FIFO_DEPTH   = 4;

    localparam int PIXELS    = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CH_IDX_W  = $clog2(CHANNELS);
    localparam int PIX_IDX_W = $clog2(PIXELS);

    // Element [i] is channel i.
    typedef logic [CHANNELS-1:0][DATA_BITS-1:0] pixel_vec_t;

endpackage

// File: rtl/relu2_channel_serializer_vec_fifo.sv
// Synchronous FIFO of whole pixel vectors; head is read combinationally.
module relu2_channel_serializer_vec_fifo #(
    parameter int WIDTH = 2048,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO is fine when the head leaves on the same edge.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/relu2_channel_serializer.sv
// Buffers ReLU-2 pixel vectors and re-emits them one channel word per
// transfer with channel/pixel tags and frame markers.
module relu2_channel_serializer #(
    parameter int IMAGE_WIDTH  = relu2_channel_serializer_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = relu2_channel_serializer_pkg::IMAGE_HEIGHT,
    parameter int CHANNELS     = relu2_channel_serializer_pkg::CHANNELS,
    parameter int DATA_BITS    = relu2_channel_serializer_pkg::DATA_BITS,
    parameter int FIFO_DEPTH   = relu2_channel_serializer_pkg::FIFO_DEPTH
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      valid_in,
    input  logic [CHANNELS-1:0][DATA_BITS-1:0]        data_in,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [DATA_BITS-1:0]                      out_data,
    output logic [$clog2(CHANNELS)-1:0]               out_channel,
    output logic [$clog2(IMAGE_WIDTH*IMAGE_HEIGHT)-1:0] out_pixel,
    output logic                                      out_last_ch,
    output logic                                      out_last_frame,
    output logic                                      overflow,
    output logic                                      busy
);
    import relu2_channel_serializer_pkg::*;

    localparam int PIX_N = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CH_W  = $clog2(CHANNELS);
    localparam int PIX_W = $clog2(PIX_N);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_N - 1);

    typedef logic [CHANNELS-1:0][DATA_BITS-1:0] vec_t;

    vec_t             head;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [CH_W-1:0]  ch_idx;
    logic [PIX_W-1:0] pix_idx;
    logic             load_cond;
    logic             load;
    logic             pop;
    logic             push;

    assign load_cond = !out_valid || out_ready;
    assign load      = load_cond && !empty;
    assign pop       = load && (ch_idx == CH_LAST);
    assign push      = valid_in && (!full || pop);
    assign busy      = (count != '0) || out_valid;

    relu2_channel_serializer_vec_fifo #(
        .WIDTH (CHANNELS * DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (data_in),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_channel    <= '0;
            out_pixel      <= '0;
            out_last_ch    <= 1'b0;
            out_last_frame <= 1'b0;
            overflow       <= 1'b0;
            ch_idx         <= '0;
            pix_idx        <= '0;
        end else begin
            if (valid_in && !push) overflow <= 1'b1;
            if (load) begin
                out_valid      <= 1'b1;
                out_data       <= head[ch_idx];
                out_channel    <= ch_idx;
                out_pixel      <= pix_idx;
                out_last_ch    <= (ch_idx == CH_LAST);
                out_last_frame <= (ch_idx == CH_LAST) && (pix_idx == PIX_LAST);
                if (ch_idx == CH_LAST) begin
                    ch_idx  <= '0;
                    pix_idx <= (pix_idx == PIX_LAST) ? '0 : pix_idx + 1'b1;
                end else begin
                    ch_idx <= ch_idx + 1'b1;
                end
            end else if (load_cond) begin
                // Nothing buffered: the word just accepted is not replaced.
                out_valid <= 1'b0;
            end
        end
    end

endmodule
